// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the fetch / memory-stage port arbiter.
package y86_mem_pkg;

  localparam int MEM_DATA_W     = 64;
  localparam int DEFAULT_DEPTH  = 512;
  localparam int DEFAULT_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_t;

  // A word address is usable only if it is below DEPTH; any set upper bit makes it out of range.
  function automatic logic addr_in_range(input logic [MEM_DATA_W-1:0] addr,
                                         input int unsigned depth);
    return addr < MEM_DATA_W'(depth);
  endfunction

endpackage

// File: rtl/arb_fair_counter.sv
// Counts consecutive arbitration losses of the fetch requester and forces a
// fetch win once the count reaches FAIR_LIMIT. FAIR_LIMIT = 0 disables forcing.
module arb_fair_counter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_fire,
  input  logic if_req,
  input  logic if_won,
  output logic force_if
);

  localparam int CNT_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

  logic [CNT_W-1:0] cnt_reg;

  // Loss counter: cleared when fetch stops asking or wins, saturating increment on each loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!if_req) begin
      cnt_reg <= '0;
    end else if (arb_fire) begin
      if (if_won) begin
        cnt_reg <= '0;
      end else if (cnt_reg != LIMIT) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign force_if = (FAIR_LIMIT > 0) && (cnt_reg == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported data memory shared between instruction fetch (read-only) and the
// memory stage. Memory stage has priority; fetch is protected from starvation by
// a loss counter. One access in flight, fixed read latency, registered outputs.
module mem_port_arbiter
  import y86_mem_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int READ_LATENCY = 1,
  parameter int FAIR_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [MEM_DATA_W-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [MEM_DATA_W-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [MEM_DATA_W-1:0] dm_addr,
  input  logic [MEM_DATA_W-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [MEM_DATA_W-1:0] dm_rdata,
  output logic                  dm_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  busy
);

  localparam int WCNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  arb_state_t state_reg, state_next;
  requester_t winner_reg, sel_winner;
  logic       we_reg, err_reg;
  logic [WCNT_W-1:0] wait_cnt_reg;

  logic arb_point, arb_fire, force_if, pick_if, sel_we, sel_ok, wait_done, resp_enter;
  logic [MEM_DATA_W-1:0] sel_addr, sel_wdata;

  logic                  if_gnt_reg, if_gnt_next, if_rvalid_reg, if_rvalid_next;
  logic                  if_err_reg, if_err_next;
  logic [MEM_DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic                  dm_gnt_reg, dm_gnt_next, dm_rvalid_reg, dm_rvalid_next;
  logic                  dm_err_reg, dm_err_next;
  logic [MEM_DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic                  mem_en_reg, mem_en_next, mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;
  logic [MEM_DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic                  busy_reg, busy_next;

  // Requests are only looked at when no access is in flight (IDLE) or one is finishing (RESP).
  assign arb_point  = (state_reg == IDLE) || (state_reg == RESP);
  assign arb_fire   = arb_point && (if_req || dm_req);
  assign pick_if    = if_req && (!dm_req || force_if);
  assign sel_winner = pick_if ? REQ_IF : REQ_DM;
  assign sel_we     = pick_if ? 1'b0 : dm_we;
  assign sel_addr   = pick_if ? if_addr : dm_addr;
  assign sel_wdata  = pick_if ? '0 : dm_wdata;
  assign sel_ok     = addr_in_range(sel_addr, DEPTH);
  assign wait_done  = (wait_cnt_reg == WCNT_W'(READ_LATENCY - 1));
  assign resp_enter = (state_next == RESP);

  arb_fair_counter #(
    .FAIR_LIMIT(FAIR_LIMIT)
  ) u_fair (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_fire(arb_fire),
    .if_req  (if_req),
    .if_won  (pick_if),
    .force_if(force_if)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; RESP chains straight into the next access when someone is waiting.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (arb_fire) state_next = ISSUE;
      ISSUE:   state_next = err_reg ? RESP : WAIT;
      WAIT:    if (wait_done) state_next = RESP;
      RESP:    state_next = arb_fire ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs: grant and strobe on entering ISSUE, response on entering RESP.
  always_comb begin
    logic [MEM_DATA_W-1:0] resp_data;
    resp_data      = '0;
    if_gnt_next    = 1'b0;
    if_rvalid_next = 1'b0;
    if_rdata_next  = '0;
    if_err_next    = 1'b0;
    dm_gnt_next    = 1'b0;
    dm_rvalid_next = 1'b0;
    dm_rdata_next  = '0;
    dm_err_next    = 1'b0;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    if (arb_fire) begin
      if_gnt_next = pick_if;
      dm_gnt_next = !pick_if;
      if (sel_ok) begin
        mem_en_next    = 1'b1;
        mem_we_next    = sel_we;
        mem_addr_next  = sel_addr[ADDR_W-1:0];
        mem_wdata_next = sel_wdata;
      end
    end
    if (resp_enter) begin
      // Read data is live on the last WAIT cycle; writes and errors answer with zero.
      resp_data = ((state_reg == WAIT) && !we_reg) ? mem_rdata : '0;
      if (winner_reg == REQ_IF) begin
        if_rvalid_next = 1'b1;
        if_rdata_next  = resp_data;
        if_err_next    = err_reg;
      end else begin
        dm_rvalid_next = 1'b1;
        dm_rdata_next  = resp_data;
        dm_err_next    = err_reg;
      end
    end
    busy_next = (state_next != IDLE);
  end

  // Output registers; reset clears them at once so an in-flight strobe is withdrawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_gnt_reg    <= 1'b0;
      if_rvalid_reg <= 1'b0;
      if_rdata_reg  <= '0;
      if_err_reg    <= 1'b0;
      dm_gnt_reg    <= 1'b0;
      dm_rvalid_reg <= 1'b0;
      dm_rdata_reg  <= '0;
      dm_err_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      if_gnt_reg    <= if_gnt_next;
      if_rvalid_reg <= if_rvalid_next;
      if_rdata_reg  <= if_rdata_next;
      if_err_reg    <= if_err_next;
      dm_gnt_reg    <= dm_gnt_next;
      dm_rvalid_reg <= dm_rvalid_next;
      dm_rdata_reg  <= dm_rdata_next;
      dm_err_reg    <= dm_err_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      busy_reg      <= busy_next;
    end
  end

  // Latched transaction attributes and the read-latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_reg   <= REQ_IF;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      if (arb_fire) begin
        winner_reg <= sel_winner;
        we_reg     <= sel_we;
        err_reg    <= !sel_ok;
      end
      if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + WCNT_W'(1);
      else                   wait_cnt_reg <= '0;
    end
  end

  assign if_gnt    = if_gnt_reg;
  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign if_err    = if_err_reg;
  assign dm_gnt    = dm_gnt_reg;
  assign dm_rvalid = dm_rvalid_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign dm_err    = dm_err_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;

endmodule
